// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: state encoding, BCD digit limits and disp_bcd field layout
// shared by the stopwatch counting core and its digit counters.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        OVF   = 2'd3
    } sw_state_e;

    localparam logic [3:0] TENTHS_MAX    = 4'd9;
    localparam logic [3:0] SEC_UNITS_MAX = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX  = 4'd5;

    localparam int TENTHS_LSB    = 0;
    localparam int SEC_UNITS_LSB = 4;
    localparam int SEC_TENS_LSB  = 8;
    localparam int MINUTES_LSB   = 12;

endpackage

// File: rtl/stopwatch_core_bcd_digit_cnt.sv
// bcd_digit_cnt: one BCD digit counting 0..MAX with synchronous clear;
// carry fires on the increment that wraps the digit back to zero.
module bcd_digit_cnt
    import stopwatch_pkg::*;
#(
    parameter logic [3:0] MAX = TENTHS_MAX
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] digit,
    output logic       carry
);

    logic [3:0] digit_q, digit_d;

    always_comb begin
        digit_d = digit_q;
        if (clr) begin
            digit_d = 4'd0;
        end else if (inc) begin
            digit_d = (digit_q == MAX) ? 4'd0 : digit_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit = digit_q;
    assign carry = inc & (digit_q == MAX);

endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core: synchronizes the slow tick, gates a saturating M:SS.t BCD
// count with a start/pause/clear FSM; optional lap hold via STOPWATCH_LAP_EN.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_MINUTES = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_in,
    input  logic        btn_start_stop,
    input  logic        btn_clear,
    input  logic        btn_lap,
    output logic [15:0] disp_bcd,
    output logic        running,
    output logic        lap_active,
    output logic        overflow
);

    // Extra stage beyond the synchronizer gives the edge detector its history bit.
    logic [SYNC_STAGES:0] sync_q, sync_d;
    logic                 tick_pulse_q, tick_pulse_d;

    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-1:0], tick_in};
        tick_pulse_d = sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            tick_pulse_q <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            tick_pulse_q <= tick_pulse_d;
        end
    end

    sw_state_e   state_q, state_d;
    logic        running_q, running_d;
    logic        overflow_q, overflow_d;
    logic        count_clr, count_en, count_inc, at_max, enter_ovf;
    logic [3:0]  tenths, sec_units, sec_tens, minutes;
    logic        c_tenths, c_units, c_tens, min_carry_unused;
    logic [15:0] live_count;

    assign count_en  = (state_q == RUN) & tick_pulse_q;
    assign at_max    = (minutes == 4'(MAX_MINUTES)) && (sec_tens == SEC_TENS_MAX) &&
                       (sec_units == SEC_UNITS_MAX) && (tenths == TENTHS_MAX);
    assign count_inc = count_en & ~at_max;

    bcd_digit_cnt #(.MAX(TENTHS_MAX)) u_tenths (
        .clk(clk), .rst_n(rst_n), .clr(count_clr), .inc(count_inc),
        .digit(tenths), .carry(c_tenths));
    bcd_digit_cnt #(.MAX(SEC_UNITS_MAX)) u_sec_units (
        .clk(clk), .rst_n(rst_n), .clr(count_clr), .inc(c_tenths),
        .digit(sec_units), .carry(c_units));
    bcd_digit_cnt #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk(clk), .rst_n(rst_n), .clr(count_clr), .inc(c_units),
        .digit(sec_tens), .carry(c_tens));
    bcd_digit_cnt #(.MAX(4'(MAX_MINUTES))) u_minutes (
        .clk(clk), .rst_n(rst_n), .clr(count_clr), .inc(c_tens),
        .digit(minutes), .carry(min_carry_unused));

    always_comb begin
        live_count = '0;
        live_count[MINUTES_LSB   +: 4] = minutes;
        live_count[SEC_TENS_LSB  +: 4] = sec_tens;
        live_count[SEC_UNITS_LSB +: 4] = sec_units;
        live_count[TENTHS_LSB    +: 4] = tenths;
    end

    // A tick at full scale is consumed by the overflow transition, so it wins over start_stop.
    always_comb begin
        state_d   = state_q;
        count_clr = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (btn_clear)           count_clr = 1'b1;
                else if (btn_start_stop) state_d   = RUN;
            end
            RUN: begin
                if (count_en && at_max)  state_d = OVF;
                else if (btn_start_stop) state_d = PAUSE;
            end
            PAUSE: begin
                if (btn_clear) begin
                    state_d   = IDLE;
                    count_clr = 1'b1;
                end else if (btn_start_stop) begin
                    state_d = RUN;
                end
            end
            OVF: begin
                if (btn_clear) begin
                    state_d   = IDLE;
                    count_clr = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        enter_ovf  = (state_q == RUN) && (state_d == OVF);
        running_d  = (state_d == RUN);
        overflow_d = (state_d == OVF);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            running_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            running_q  <= running_d;
            overflow_q <= overflow_d;
        end
    end

    assign running  = running_q;
    assign overflow = overflow_q;

    logic [15:0] disp_q, disp_d;

`ifdef STOPWATCH_LAP_EN
    logic        lap_active_q, lap_active_d;
    logic [15:0] lap_q, lap_d;

    always_comb begin
        lap_active_d = lap_active_q;
        lap_d        = lap_q;
        if (enter_ovf || count_clr) begin
            lap_active_d = 1'b0;
        end else if (btn_lap) begin
            if (state_q == RUN) begin
                lap_active_d = ~lap_active_q;
                if (!lap_active_q) lap_d = live_count;
            end else begin
                lap_active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_active_q <= 1'b0;
            lap_q        <= '0;
        end else begin
            lap_active_q <= lap_active_d;
            lap_q        <= lap_d;
        end
    end

    assign disp_d     = lap_active_q ? lap_q : live_count;
    assign lap_active = lap_active_q;
`else
    logic lap_unused;
    assign lap_unused = btn_lap ^ enter_ovf;
    assign disp_d     = live_count;
    assign lap_active = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q <= '0;
        end else begin
            disp_q <= disp_d;
        end
    end

    assign disp_bcd = disp_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: directed scoreboard bench for stopwatch_core; follows
// STOPWATCH_LAP_EN when it is defined for the build.
module tb_stopwatch_core;

    localparam int MAX_CNT = 9 * 600 + 599;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick_in = 1'b0;
    logic        btn_start_stop = 1'b0;
    logic        btn_clear = 1'b0;
    logic        btn_lap = 1'b0;
    logic [15:0] disp_bcd;
    logic        running;
    logic        lap_active;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    stopwatch_core #(.SYNC_STAGES(2), .MAX_MINUTES(9)) dut (
        .clk(clk), .rst_n(rst_n), .tick_in(tick_in),
        .btn_start_stop(btn_start_stop), .btn_clear(btn_clear), .btn_lap(btn_lap),
        .disp_bcd(disp_bcd), .running(running), .lap_active(lap_active),
        .overflow(overflow));

    always #5 clk = ~clk;

    typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_OVF} m_state_e;
    typedef struct {
        string       tag;
        logic [18:0] val;
    } exp_t;

    exp_t        sb[$];
    m_state_e    m_state = M_IDLE;
    int          m_cnt = 0;
    bit          m_lap = 1'b0;
    logic [15:0] m_lap_val = '0;

    function automatic logic [15:0] to_bcd(input int n);
        int sec;
        sec = (n % 600) / 10;
        return {4'(n / 600), 4'(sec / 10), 4'(sec % 10), 4'(n % 10)};
    endfunction

    // Reference model advanced once per clock in which stimulus is applied.
    function automatic void model_step(input bit tick, input bit ss, input bit clr, input bit lap);
        m_state_e nxt = m_state;
        int       old_cnt = m_cnt;
        bit       to_ovf = 1'b0;
        bit       zeroed = 1'b0;
        if (m_state == M_RUN && tick) begin
            if (m_cnt == MAX_CNT) to_ovf = 1'b1;
            else m_cnt++;
        end
        case (m_state)
            M_IDLE:  if (clr) begin m_cnt = 0; zeroed = 1'b1; end
                     else if (ss) nxt = M_RUN;
            M_RUN:   if (to_ovf) nxt = M_OVF;
                     else if (ss) nxt = M_PAUSE;
            M_PAUSE: if (clr) begin nxt = M_IDLE; m_cnt = 0; zeroed = 1'b1; end
                     else if (ss) nxt = M_RUN;
            M_OVF:   if (clr) begin nxt = M_IDLE; m_cnt = 0; zeroed = 1'b1; end
            default: nxt = M_IDLE;
        endcase
`ifdef STOPWATCH_LAP_EN
        if (to_ovf || zeroed) m_lap = 1'b0;
        else if (lap) begin
            if (m_state == M_RUN) begin
                if (!m_lap) m_lap_val = to_bcd(old_cnt);
                m_lap = !m_lap;
            end else begin
                m_lap = 1'b0;
            end
        end
`endif
        m_state = nxt;
    endfunction

    function automatic void model_reset();
        m_state = M_IDLE;
        m_cnt = 0;
        m_lap = 1'b0;
        m_lap_val = '0;
    endfunction

    function automatic void expect_model(input string tag);
        exp_t e;
        e.tag = tag;
        e.val = {(m_lap ? m_lap_val : to_bcd(m_cnt)), (m_state == M_RUN),
                 (m_state == M_OVF), m_lap};
        sb.push_back(e);
    endfunction

    function automatic void expect_value(input string tag, input logic [18:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output();
        exp_t        e;
        logic [18:0] obs;
        obs = {disp_bcd, running, overflow, lap_active};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("[TB] FAIL scoreboard_empty: observed %h, required a queued expectation", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("[TB] FAIL %s: observed disp=%h run=%b ovf=%b lap=%b, expected disp=%h run=%b ovf=%b lap=%b",
                       e.tag, obs[18:3], obs[2], obs[1], obs[0],
                       e.val[18:3], e.val[2], e.val[1], e.val[0]);
            end
        end
    endtask

    // Tick with 3-clk high/low phases; buttons land in the clock that consumes the tick pulse.
    task automatic apply_tick(input bit ss, input bit clr, input bit lap);
        tick_in = 1'b1;
        step(); step(); step();
        tick_in = 1'b0;
        btn_start_stop = ss; btn_clear = clr; btn_lap = lap;
        step();
        btn_start_stop = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;
        step(); step();
        model_step(1'b1, ss, clr, lap);
    endtask

    task automatic apply_ticks(input int n);
        for (int i = 0; i < n; i++) apply_tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic apply_press(input bit ss, input bit clr, input bit lap);
        btn_start_stop = ss; btn_clear = clr; btn_lap = lap;
        step();
        btn_start_stop = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;
        step();
        model_step(1'b0, ss, clr, lap);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        model_reset();
        step(); step();
        expect_model("reset_values");
        check_output();
        rst_n = 1'b1;
        step();

        apply_press(1'b1, 1'b0, 1'b0);
        expect_model("start_running");
        check_output();

        tick_in = 1'b1;
        step(); step(); step();
        tick_in = 1'b0;
        step();
        expect_value("tick_latency_early", {16'h0000, 1'b1, 1'b0, 1'b0});
        check_output();
        step();
        expect_value("tick_latency_first", {16'h0001, 1'b1, 1'b0, 1'b0});
        check_output();
        step();
        model_step(1'b1, 1'b0, 1'b0, 1'b0);

        apply_ticks(24);
        expect_value("count_25", {16'h0025, 1'b1, 1'b0, 1'b0});
        check_output();

        apply_press(1'b1, 1'b0, 1'b0);
        apply_press(1'b0, 1'b1, 1'b0);
        expect_value("pause_clear_idle", {16'h0000, 1'b0, 1'b0, 1'b0});
        check_output();

        apply_press(1'b1, 1'b0, 1'b0);
        apply_ticks(7);
        apply_tick(1'b1, 1'b0, 1'b0);
        expect_value("pause_with_tick", {16'h0008, 1'b0, 1'b0, 1'b0});
        check_output();
        apply_ticks(5);
        expect_model("paused_ticks_ignored");
        check_output();
        apply_press(1'b1, 1'b1, 1'b0);
        expect_value("clear_beats_start", {16'h0000, 1'b0, 1'b0, 1'b0});
        check_output();

        apply_tick(1'b1, 1'b0, 1'b0);
        expect_value("start_tick_not_counted", {16'h0000, 1'b1, 1'b0, 1'b0});
        check_output();

        apply_ticks(12);
        apply_press(1'b0, 1'b0, 1'b1);
        expect_model("lap_set");
        check_output();
        apply_ticks(30);
        expect_model("lap_hold");
        check_output();
        apply_press(1'b0, 1'b0, 1'b1);
        expect_value("lap_release", {16'h0042, 1'b1, 1'b0, 1'b0});
        check_output();

        apply_press(1'b1, 1'b0, 1'b0);
        apply_press(1'b0, 1'b1, 1'b0);
        apply_press(1'b1, 1'b0, 1'b0);
        apply_ticks(MAX_CNT);
        expect_value("full_scale", {16'h9599, 1'b1, 1'b0, 1'b0});
        check_output();
        apply_tick(1'b0, 1'b0, 1'b0);
        expect_value("overflow_enter", {16'h9599, 1'b0, 1'b1, 1'b0});
        check_output();
        apply_tick(1'b0, 1'b0, 1'b0);
        apply_press(1'b1, 1'b0, 1'b0);
        expect_model("overflow_saturate");
        check_output();
        apply_press(1'b0, 1'b1, 1'b0);
        expect_value("overflow_clear", {16'h0000, 1'b0, 1'b0, 1'b0});
        check_output();

        apply_press(1'b1, 1'b0, 1'b0);
        apply_ticks(317);
        expect_value("pre_reset_count", {16'h0317, 1'b1, 1'b0, 1'b0});
        check_output();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        expect_model("async_reset");
        check_output();
        step();
        rst_n = 1'b1;
        apply_ticks(3);
        expect_value("post_reset_no_count", {16'h0000, 1'b0, 1'b0, 1'b0});
        check_output();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
